// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the MIG native-UI bridge.
package ram_ctrl_pkg;

   typedef enum logic [2:0] {
      StInit,
      StIdle,
      StRdCmd,
      StRdWait,
      StWr
   } state_e;

   localparam logic [2:0] CMD_READ  = 3'b001;
   localparam logic [2:0] CMD_WRITE = 3'b000;

   localparam int unsigned NUM_ERR         = 4;
   localparam int unsigned ERR_TRIG_DROP   = 0;
   localparam int unsigned ERR_SPURIOUS_RD = 1;
   localparam int unsigned ERR_RESERVED    = 2;
   localparam int unsigned ERR_CALIB_LOST  = 3;

endpackage

// File: rtl/ram_controller.sv
// Single-beat bridge from a pulse-triggered read/write port to the MIG 7-series native UI.
module ram_controller
   import ram_ctrl_pkg::*;
#(
   parameter int unsigned CHUNK_PART   = 128,
   parameter int unsigned ADDRESS_SIZE = 28
) (
   input  logic                    clk,
   input  logic                    rst_n,
   output logic                    controller_ready,
   output logic [NUM_ERR-1:0]      error,
   output logic [2:0]              led0,
   input  logic                    write_trigger,
   input  logic [CHUNK_PART-1:0]   write_value,
   input  logic [ADDRESS_SIZE-1:0] write_address,
   input  logic                    read_trigger,
   input  logic [ADDRESS_SIZE-1:0] read_address,
   output logic [CHUNK_PART-1:0]   read_value,
   output logic                    read_value_ready,
   output logic [ADDRESS_SIZE-1:0] mig_app_addr,
   output logic [2:0]              mig_app_cmd,
   output logic                    mig_app_en,
   output logic [CHUNK_PART-1:0]   mig_app_wdf_data,
   output logic                    mig_app_wdf_end,
   output logic [CHUNK_PART/8-1:0] mig_app_wdf_mask,
   output logic                    mig_app_wdf_wren,
   input  logic                    mig_app_wdf_rdy,
   input  logic [CHUNK_PART-1:0]   mig_app_rd_data,
   input  logic                    mig_app_rd_data_end,
   input  logic                    mig_app_rd_data_valid,
   input  logic                    mig_app_rdy,
   input  logic                    mig_init_calib_complete
);

   state_e                  state_q, state_d;
   logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
   logic [CHUNK_PART-1:0]   wdata_q, wdata_d;
   logic [CHUNK_PART-1:0]   rdata_q, rdata_d;
   logic                    rd_ready_q, rd_ready_d;
   logic                    cmd_done_q, cmd_done_d;
   logic                    data_done_q, data_done_d;
   logic [NUM_ERR-1:0]      error_q, error_d;
   logic                    calib_q;

   logic any_trigger;
   logic cmd_ok;
   logic data_ok;
   logic unused_rd_data_end;

   // Only single-beat reads are issued, so the end marker carries no information.
   assign unused_rd_data_end = mig_app_rd_data_end;

   assign any_trigger = read_trigger | write_trigger;
   assign cmd_ok      = cmd_done_q | mig_app_rdy;
   assign data_ok     = data_done_q | mig_app_wdf_rdy;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      rd_ready_d  = 1'b0;
      cmd_done_d  = cmd_done_q;
      data_done_d = data_done_q;
      error_d     = error_q;

      if (mig_app_rd_data_valid && (state_q != StRdWait)) begin
         error_d[ERR_SPURIOUS_RD] = 1'b1;
      end

      // Losing calibration abandons whatever is in flight.
      if ((state_q != StInit) && !mig_init_calib_complete) begin
         state_d                 = StInit;
         cmd_done_d              = 1'b0;
         data_done_d             = 1'b0;
         error_d[ERR_CALIB_LOST] = 1'b1;
         if (any_trigger) begin
            error_d[ERR_TRIG_DROP] = 1'b1;
         end
      end else begin
         if (any_trigger && (state_q != StIdle)) begin
            error_d[ERR_TRIG_DROP] = 1'b1;
         end

         unique case (state_q)
            StInit: begin
               if (mig_init_calib_complete) begin
                  state_d = StIdle;
               end
            end

            StIdle: begin
               if (read_trigger) begin
                  addr_d  = read_address;
                  state_d = StRdCmd;
                  if (write_trigger) begin
                     error_d[ERR_TRIG_DROP] = 1'b1;
                  end
               end else if (write_trigger) begin
                  addr_d      = write_address;
                  wdata_d     = write_value;
                  cmd_done_d  = 1'b0;
                  data_done_d = 1'b0;
                  state_d     = StWr;
               end
            end

            StRdCmd: begin
               if (mig_app_rdy) begin
                  state_d = StRdWait;
               end
            end

            StRdWait: begin
               if (mig_app_rd_data_valid) begin
                  rdata_d    = mig_app_rd_data;
                  rd_ready_d = 1'b1;
                  state_d    = StIdle;
               end
            end

            StWr: begin
               // Command and data handshakes complete independently.
               cmd_done_d  = cmd_ok;
               data_done_d = data_ok;
               if (cmd_ok && data_ok) begin
                  cmd_done_d  = 1'b0;
                  data_done_d = 1'b0;
                  state_d     = StIdle;
               end
            end

            default: state_d = StInit;
         endcase
      end

      error_d[ERR_RESERVED] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StInit;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         rd_ready_q  <= 1'b0;
         cmd_done_q  <= 1'b0;
         data_done_q <= 1'b0;
         error_q     <= '0;
         calib_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         rd_ready_q  <= rd_ready_d;
         cmd_done_q  <= cmd_done_d;
         data_done_q <= data_done_d;
         error_q     <= error_d;
         calib_q     <= mig_init_calib_complete;
      end
   end

   // Idle is only reachable with calibration held, so the state alone implies ready.
   assign controller_ready = (state_q == StIdle);
   assign error            = error_q;
   assign led0             = {(state_q == StWr), (state_q == StRdCmd) || (state_q == StRdWait),
                              calib_q};
   assign read_value       = rdata_q;
   assign read_value_ready = rd_ready_q;

   assign mig_app_addr     = addr_q;
   assign mig_app_cmd      = (state_q == StRdCmd) ? CMD_READ : CMD_WRITE;
   assign mig_app_en       = (state_q == StRdCmd) || ((state_q == StWr) && !cmd_done_q);
   assign mig_app_wdf_data = wdata_q;
   assign mig_app_wdf_wren = (state_q == StWr) && !data_done_q;
   assign mig_app_wdf_end  = mig_app_wdf_wren;
   assign mig_app_wdf_mask = '0;

endmodule

// File: tb/tb_ram_controller.sv
// Self-checking bench: transaction-level reference model, per-cycle compare, directed + random.
module tb_ram_controller;

   localparam int unsigned CP = 128;
   localparam int unsigned AS = 28;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          controller_ready;
   logic [3:0]    error;
   logic [2:0]    led0;
   logic          write_trigger;
   logic [CP-1:0] write_value;
   logic [AS-1:0] write_address;
   logic          read_trigger;
   logic [AS-1:0] read_address;
   logic [CP-1:0] read_value;
   logic          read_value_ready;
   logic [AS-1:0] mig_app_addr;
   logic [2:0]    mig_app_cmd;
   logic          mig_app_en;
   logic [CP-1:0] mig_app_wdf_data;
   logic          mig_app_wdf_end;
   logic [CP/8-1:0] mig_app_wdf_mask;
   logic          mig_app_wdf_wren;
   logic          mig_app_wdf_rdy;
   logic [CP-1:0] mig_app_rd_data;
   logic          mig_app_rd_data_end;
   logic          mig_app_rd_data_valid;
   logic          mig_app_rdy;
   logic          mig_init_calib_complete;

   always #5 clk = ~clk;

   ram_controller #(
      .CHUNK_PART  (CP),
      .ADDRESS_SIZE(AS)
   ) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .controller_ready       (controller_ready),
      .error                  (error),
      .led0                   (led0),
      .write_trigger          (write_trigger),
      .write_value            (write_value),
      .write_address          (write_address),
      .read_trigger           (read_trigger),
      .read_address           (read_address),
      .read_value             (read_value),
      .read_value_ready       (read_value_ready),
      .mig_app_addr           (mig_app_addr),
      .mig_app_cmd            (mig_app_cmd),
      .mig_app_en             (mig_app_en),
      .mig_app_wdf_data       (mig_app_wdf_data),
      .mig_app_wdf_end        (mig_app_wdf_end),
      .mig_app_wdf_mask       (mig_app_wdf_mask),
      .mig_app_wdf_wren       (mig_app_wdf_wren),
      .mig_app_wdf_rdy        (mig_app_wdf_rdy),
      .mig_app_rd_data        (mig_app_rd_data),
      .mig_app_rd_data_end    (mig_app_rd_data_end),
      .mig_app_rd_data_valid  (mig_app_rd_data_valid),
      .mig_app_rdy            (mig_app_rdy),
      .mig_init_calib_complete(mig_init_calib_complete)
   );

   int checks   = 0;
   int failures = 0;

   task automatic report(input string name, input logic [CP-1:0] act, input logic [CP-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40) begin
            $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, exp);
         end
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      report(name, CP'(act), CP'(exp));
   endtask

   task automatic chkn(input string name, input int act, input int exp);
      report(name, CP'(act), CP'(exp));
   endtask

   // Reference model: what the bridge owes the MIG and the user, in transaction terms.
   typedef enum int {TxNone, TxRead, TxWrite} txn_e;

   bit            m_started = 1'b0;
   bit            m_up;
   txn_e          m_txn;
   bit            m_cmd_owed;
   bit            m_data_owed;
   logic [AS-1:0] m_addr;
   logic [CP-1:0] m_wdata;
   logic [CP-1:0] m_rv;
   bit            m_rvr;
   logic [3:0]    m_err;
   bit            m_calib;

   int n_cmd  = 0;
   int n_beat = 0;
   int n_rvr  = 0;

   always @(posedge clk) begin
      bit trig;
      m_started = 1'b1;
      trig      = read_trigger || write_trigger;
      if (!rst_n) begin
         m_up        = 1'b0;
         m_txn       = TxNone;
         m_cmd_owed  = 1'b0;
         m_data_owed = 1'b0;
         m_addr      = '0;
         m_wdata     = '0;
         m_rv        = '0;
         m_rvr       = 1'b0;
         m_err       = '0;
         m_calib     = 1'b0;
      end else begin
         m_rvr = 1'b0;
         if (mig_app_rd_data_valid && !(m_txn == TxRead && !m_cmd_owed)) m_err[1] = 1'b1;
         if (m_up && !mig_init_calib_complete) begin
            m_err[3]    = 1'b1;
            m_up        = 1'b0;
            m_txn       = TxNone;
            m_cmd_owed  = 1'b0;
            m_data_owed = 1'b0;
            if (trig) m_err[0] = 1'b1;
         end else if (!m_up) begin
            if (trig) m_err[0] = 1'b1;
            m_up = mig_init_calib_complete;
         end else if (m_txn == TxNone) begin
            if (read_trigger) begin
               m_txn      = TxRead;
               m_addr     = read_address;
               m_cmd_owed = 1'b1;
               if (write_trigger) m_err[0] = 1'b1;
            end else if (write_trigger) begin
               m_txn       = TxWrite;
               m_addr      = write_address;
               m_wdata     = write_value;
               m_cmd_owed  = 1'b1;
               m_data_owed = 1'b1;
            end
         end else begin
            if (trig) m_err[0] = 1'b1;
            if (m_txn == TxRead) begin
               if (m_cmd_owed) begin
                  if (mig_app_rdy) m_cmd_owed = 1'b0;
               end else if (mig_app_rd_data_valid) begin
                  m_rv  = mig_app_rd_data;
                  m_rvr = 1'b1;
                  m_txn = TxNone;
               end
            end else begin
               if (mig_app_rdy) m_cmd_owed = 1'b0;
               if (mig_app_wdf_rdy) m_data_owed = 1'b0;
               if (!m_cmd_owed && !m_data_owed) m_txn = TxNone;
            end
         end
         m_calib = mig_init_calib_complete;
      end
   end

   always @(negedge clk) begin
      if (m_started) begin
         chk1("ready", controller_ready, m_up && m_txn == TxNone);
         chk1("app_en", mig_app_en, m_txn != TxNone && m_cmd_owed);
         if (m_txn != TxNone && m_cmd_owed) begin
            report("app_cmd", CP'(mig_app_cmd), (m_txn == TxRead) ? CP'(1) : CP'(0));
            report("app_addr", CP'(mig_app_addr), CP'(m_addr));
         end
         chk1("wdf_wren", mig_app_wdf_wren, m_txn == TxWrite && m_data_owed);
         chk1("wdf_end", mig_app_wdf_end, m_txn == TxWrite && m_data_owed);
         if (m_txn == TxWrite && m_data_owed) report("wdf_data", mig_app_wdf_data, m_wdata);
         report("wdf_mask", CP'(mig_app_wdf_mask), '0);
         report("read_value", read_value, m_rv);
         chk1("read_value_ready", read_value_ready, m_rvr);
         report("error", CP'(error), CP'(m_err));
         report("led0", CP'(led0), CP'({m_txn == TxWrite, m_txn == TxRead, m_calib}));
         if (mig_app_en && mig_app_rdy) n_cmd++;
         if (mig_app_wdf_wren && mig_app_wdf_rdy) n_beat++;
         if (read_value_ready) n_rvr++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (controller_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (controller_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s: controller_ready=%b required 1 within 50 cycles", name, controller_ready);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   localparam logic [CP-1:0] RD_PAT = 128'h0123456789ABCDEF_FEDCBA9876543210;
   localparam logic [CP-1:0] WR_PAT = 128'hDEADBEEF_DEADBEEF_FEEDFACE_FEEDFACE;

   initial begin
      int c0;
      int b0;
      int r0;
      bit spur;
      rst_n                   = 1'b0;
      write_trigger           = 1'b0;
      write_value             = '0;
      write_address           = '0;
      read_trigger            = 1'b0;
      read_address            = '0;
      mig_app_wdf_rdy         = 1'b0;
      mig_app_rd_data         = '0;
      mig_app_rd_data_end     = 1'b0;
      mig_app_rd_data_valid   = 1'b0;
      mig_app_rdy             = 1'b0;
      mig_init_calib_complete = 1'b0;
      tick();
      tick();
      @(negedge clk);
      chk1("rst_ready", controller_ready, 1'b0);
      chk1("rst_en", mig_app_en, 1'b0);
      chkn("rst_error", int'(error), 0);
      report("rst_read_value", read_value, '0);
      chkn("rst_led0", int'(led0), 0);
      chkn("rst_cmd", int'(mig_app_cmd), 0);

      // Read with an always-ready MIG; data returns two cycles after the command.
      tick();
      rst_n                   = 1'b1;
      mig_init_calib_complete = 1'b1;
      mig_app_rdy             = 1'b1;
      wait_ready("t1_ready");
      tick();
      c0           = n_cmd;
      r0           = n_rvr;
      read_trigger = 1'b1;
      read_address = AS'(42);
      tick();
      read_trigger = 1'b0;
      @(negedge clk);
      chk1("t1_en", mig_app_en, 1'b1);
      chkn("t1_addr", int'(mig_app_addr), 42);
      chkn("t1_cmd", int'(mig_app_cmd), 1);
      tick();
      tick();
      mig_app_rd_data       = RD_PAT;
      mig_app_rd_data_valid = 1'b1;
      tick();
      mig_app_rd_data_valid = 1'b0;
      @(negedge clk);
      chk1("t1_rvr", read_value_ready, 1'b1);
      report("t1_read_value", read_value, RD_PAT);
      tick();
      tick();
      @(negedge clk);
      chkn("t1_cmds", n_cmd - c0, 1);
      chkn("t1_pulses", n_rvr - r0, 1);

      // Write with the data FIFO stalling one cycle.
      mig_app_wdf_rdy = 1'b0;
      wait_ready("t2_ready");
      tick();
      c0            = n_cmd;
      b0            = n_beat;
      write_trigger = 1'b1;
      write_address = AS'(84);
      write_value   = WR_PAT;
      tick();
      write_trigger = 1'b0;
      @(negedge clk);
      chk1("t2_en", mig_app_en, 1'b1);
      chkn("t2_cmd", int'(mig_app_cmd), 0);
      chkn("t2_addr", int'(mig_app_addr), 84);
      chk1("t2_wren", mig_app_wdf_wren, 1'b1);
      chk1("t2_end", mig_app_wdf_end, 1'b1);
      report("t2_data", mig_app_wdf_data, WR_PAT);
      chkn("t2_mask", int'(mig_app_wdf_mask), 0);
      tick();
      mig_app_wdf_rdy = 1'b1;
      @(negedge clk);
      chk1("t2_en_dropped", mig_app_en, 1'b0);
      chk1("t2_wren_held", mig_app_wdf_wren, 1'b1);
      chk1("t2_busy", controller_ready, 1'b0);
      tick();
      @(negedge clk);
      chk1("t2_wren_dropped", mig_app_wdf_wren, 1'b0);
      chk1("t2_idle", controller_ready, 1'b1);
      chkn("t2_cmds", n_cmd - c0, 1);
      chkn("t2_beats", n_beat - b0, 1);

      // Calibration gating.
      mig_init_calib_complete = 1'b0;
      do_reset();
      tick();
      read_trigger = 1'b1;
      read_address = AS'(7);
      tick();
      read_trigger = 1'b0;
      tick();
      @(negedge clk);
      chk1("t3_en", mig_app_en, 1'b0);
      chk1("t3_ready", controller_ready, 1'b0);
      chkn("t3_error", int'(error), 1);
      tick();
      mig_init_calib_complete = 1'b1;
      wait_ready("t3_ready_after_calib");

      // Command backpressure for five cycles.
      tick();
      mig_app_rdy  = 1'b0;
      c0           = n_cmd;
      read_trigger = 1'b1;
      read_address = AS'(28'h0ABCDEF);
      tick();
      read_trigger = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk1("t4_en_held", mig_app_en, 1'b1);
         chkn("t4_addr_held", int'(mig_app_addr), 28'h0ABCDEF);
         chkn("t4_cmd_held", int'(mig_app_cmd), 1);
         tick();
      end
      mig_app_rdy = 1'b1;
      tick();
      @(negedge clk);
      chk1("t4_en_dropped", mig_app_en, 1'b0);
      tick();
      mig_app_rd_data       = {$urandom, $urandom, $urandom, $urandom};
      mig_app_rd_data_valid = 1'b1;
      tick();
      mig_app_rd_data_valid = 1'b0;
      @(negedge clk);
      chk1("t4_rvr", read_value_ready, 1'b1);
      chkn("t4_cmds", n_cmd - c0, 1);

      // Simultaneous triggers, then a write trigger while busy.
      do_reset();
      wait_ready("t5_ready");
      tick();
      b0              = n_beat;
      mig_app_wdf_rdy = 1'b1;
      read_trigger    = 1'b1;
      write_trigger   = 1'b1;
      read_address    = AS'(5);
      write_address   = AS'(6);
      tick();
      read_trigger  = 1'b0;
      write_trigger = 1'b0;
      @(negedge clk);
      chk1("t5_en", mig_app_en, 1'b1);
      chkn("t5_cmd", int'(mig_app_cmd), 1);
      chk1("t5_wren", mig_app_wdf_wren, 1'b0);
      chkn("t5_error", int'(error), 1);
      tick();
      write_trigger = 1'b1;
      tick();
      write_trigger         = 1'b0;
      mig_app_rd_data       = {$urandom, $urandom, $urandom, $urandom};
      mig_app_rd_data_valid = 1'b1;
      tick();
      mig_app_rd_data_valid = 1'b0;
      tick();
      @(negedge clk);
      chkn("t5_beats", n_beat - b0, 0);
      chk1("t5_idle", controller_ready, 1'b1);

      // Reset while waiting for read data.
      tick();
      read_trigger = 1'b1;
      read_address = AS'(99);
      tick();
      read_trigger = 1'b0;
      tick();
      r0                    = n_rvr;
      rst_n                 = 1'b0;
      mig_app_rd_data       = {$urandom, $urandom, $urandom, $urandom};
      mig_app_rd_data_valid = 1'b1;
      tick();
      tick();
      @(negedge clk);
      chk1("t6_en", mig_app_en, 1'b0);
      chk1("t6_ready", controller_ready, 1'b0);
      report("t6_read_value", read_value, '0);
      chkn("t6_error", int'(error), 0);
      chkn("t6_led0", int'(led0), 0);
      tick();
      rst_n                 = 1'b1;
      mig_app_rd_data_valid = 1'b0;
      wait_ready("t6_ready_after");
      chkn("t6_no_pulse", n_rvr - r0, 0);

      // Random traffic, with spurious read data only in the second half.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         tick();
         spur  = (cyc >= 2000);
         rst_n = ($urandom_range(799) != 0);
         if (mig_init_calib_complete) begin
            mig_init_calib_complete = ($urandom_range(299) != 0);
         end else begin
            mig_init_calib_complete = ($urandom_range(7) == 0);
         end
         read_trigger    = ($urandom_range(4) == 0);
         write_trigger   = ($urandom_range(4) == 0);
         read_address    = AS'($urandom);
         write_address   = AS'($urandom);
         write_value     = {$urandom, $urandom, $urandom, $urandom};
         mig_app_rdy     = $urandom_range(1) == 1;
         mig_app_wdf_rdy = $urandom_range(1) == 1;
         mig_app_rd_data = {$urandom, $urandom, $urandom, $urandom};
         if (m_txn == TxRead && !m_cmd_owed) begin
            mig_app_rd_data_valid = ($urandom_range(2) == 0);
         end else begin
            mig_app_rd_data_valid = spur && ($urandom_range(399) == 0);
         end
         mig_app_rd_data_end = mig_app_rd_data_valid;
      end
      tick();
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ram_controller.md
Name: ram_controller

Overview:
- Single-request bridge between a simple pulse-triggered read/write user port and a Xilinx MIG 7-series native UI port (app_* signals).
- Each request transfers one CHUNK_PART-bit beat (one UI-width word).
- Sits between the CPU memory subsystem and the DDR MIG core.
- The MIG UI clock drives clk, so the whole block runs on one clock; any clock-domain crossing lives outside this block.

Parameters:
- CHUNK_PART, 128: UI data width in bits. Also sets the user data width; mask width is CHUNK_PART/8.
- ADDRESS_SIZE, 28: user and MIG address width.

Ports:
- clk  in  1  sole clock; the MIG ui_clk is connected here.
- rst_n  in  1  synchronous active-low reset.
- controller_ready  out  1  block idle and calibration done; triggers are accepted only while high.
- error  out  4  sticky error flags, cleared only by reset.
- led0  out  3  debug status.
- write_trigger  in  1  one-cycle write request.
- write_value  in  CHUNK_PART  write data, sampled with write_trigger.
- write_address  in  ADDRESS_SIZE  write address, sampled with write_trigger.
- read_trigger  in  1  one-cycle read request.
- read_address  in  ADDRESS_SIZE  read address, sampled with read_trigger.
- read_value  out  CHUNK_PART  last read data, held until the next read completes.
- read_value_ready  out  1  one-cycle pulse: read_value is valid.
- mig_app_addr  out  ADDRESS_SIZE  MIG command address.
- mig_app_cmd  out  3  001 = read, 000 = write.
- mig_app_en  out  1  command valid.
- mig_app_wdf_data  out  CHUNK_PART  write data.
- mig_app_wdf_end  out  1  last beat of write data; equals mig_app_wdf_wren.
- mig_app_wdf_mask  out  CHUNK_PART/8  byte mask; tied to all zeros (all bytes written).
- mig_app_wdf_wren  out  1  write data valid.
- mig_app_wdf_rdy  in  1  MIG write-data FIFO ready.
- mig_app_rd_data  in  CHUNK_PART  read data.
- mig_app_rd_data_end  in  1  last read beat.
- mig_app_rd_data_valid  in  1  read data valid.
- mig_app_rdy  in  1  MIG command accepted.
- mig_init_calib_complete  in  1  DDR calibration done.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs are 0, including read_value, error and mig_app_*; mig_app_cmd = 000.
  - State goes to INIT.
  - Reset mid-transaction abandons the transaction; no completion pulse is produced.
- INIT: wait for mig_init_calib_complete=1, then go to IDLE.
- IDLE:
  - controller_ready = calib_complete AND (state==IDLE), registered.
  - On read_trigger, latch read_address and go to RD_CMD.
  - Otherwise, on write_trigger, latch write_address and write_value and go to WR.
  - If both triggers are high together, the read wins; the write is dropped and error[0] is set.
- RD_CMD:
  - Drive mig_app_en=1, cmd=001, addr = latched address.
  - Hold all three until a cycle where mig_app_rdy=1; that cycle is the command handshake.
  - Then deassert mig_app_en and go to RD_WAIT.
- RD_WAIT:
  - On the first cycle with mig_app_rd_data_valid=1, register mig_app_rd_data into read_value.
  - Pulse read_value_ready for exactly 1 cycle, on the cycle after valid.
  - Return to IDLE. Single-beat transfers only; mig_app_rd_data_end is not required.
- WR:
  - Drive the command (mig_app_en=1, cmd=000, addr) and the data (wdf_wren=wdf_end=1, wdf_data = latched value) concurrently.
  - The command drops after a cycle with mig_app_rdy=1; the data drops after a cycle with mig_app_wdf_rdy=1. The two handshakes are independent and may complete in either order or together.
  - When both are done, return to IDLE.
  - Exactly one wdf_wren&wdf_end beat is accepted per write.
- Latency:
  - Trigger sampled at edge N; mig_app_en is high from cycle N+1.
  - With mig_app_rdy=1, the command is accepted at N+1.
  - controller_ready is low from N+1 until the cycle after completion.
- Triggers while busy or in INIT are ignored and set error[0].
- error bits, all sticky:
  - [0] trigger dropped.
  - [1] mig_app_rd_data_valid seen outside RD_WAIT.
  - [2] reserved, reads 0.
  - [3] mig_init_calib_complete fell after leaving INIT; the state returns to INIT.
- led0:
  - [0] calib complete.
  - [1] read in progress (RD_CMD or RD_WAIT).
  - [2] write in progress (WR).
- No timeouts; the block waits indefinitely on the MIG handshakes.

Decomposition:
- Shared package ram_ctrl_pkg holds:
  - the state enum (INIT, IDLE, RD_CMD, RD_WAIT, WR);
  - MIG command constants CMD_READ=3'b001 and CMD_WRITE=3'b000;
  - error bit index constants.
- Single module; no sub-module is warranted.

Test Plan:
- Read, MIG ready: calib=1, app_rdy=1; read_address=42 pulse; MIG returns 128'h0123456789ABCDEF_FEDCBA9876543210 two cycles after the command.
  -> One command with addr 42 and cmd 001; read_value equals that data; exactly 1 read_value_ready pulse.
- Write, delayed wdf_rdy: write_address=84, value 128'hDEADBEEF_DEADBEEF_FEEDFACE_FEEDFACE; wdf_rdy low for 1 cycle after the command.
  -> One command with cmd 000 and addr 84; exactly one wdf_wren&wdf_end beat with that value; mask=0; then back to IDLE.
- Calibration gating: calib=0 with a read_trigger pulse.
  -> No mig_app_en; controller_ready=0; error[0]=1. After calib rises, controller_ready=1.
- Command backpressure: app_rdy=0 for 5 cycles during a read.
  -> mig_app_en, addr and cmd stay stable; accepted once only.
- Simultaneous read and write triggers, or a trigger while busy.
  -> The read executes, there is no write beat, error[0]=1.
- Reset mid-RD_WAIT, then release.
  -> Outputs are 0, no read_value_ready pulse, and the block returns to IDLE after calibration.
